axi_bresp_collector: RTL
========================

// Module: axi_bresp_collector
// PURPOSE
//  Per-target-port write-response collector for the AXI node, generalised to N_INIT_PORT initiators.
//  Round-robin merges B responses from all initiator ports onto one target-side B channel.
//  Strips routing ID bits and tracks outstanding writes against MAX_OUTSTANDING.
//  Injects DECERR responses for unmapped writes, ordered behind all outstanding writes.
// PARAMETERS
//  N_INIT_PORT      4   number of initiator-side B channels merged
//  N_TARG_PORT      8   number of target ports (sets routing ID bits)
//  AXI_ID_IN        16  target-side ID width
//  AXI_ID_OUT       AXI_ID_IN+$clog2(N_TARG_PORT)  initiator-side ID width
//  AXI_USER_W       6   user width
//  MAX_OUTSTANDING  8   max writes in flight; counter width CNT_W=$clog2(MAX_OUTSTANDING+1)
// PORTS
//  clk                  in   1                       clock
//  rst                  in   1                       synchronous reset, active-high
//  bid_i                in   N_INIT_PORT*AXI_ID_OUT  initiator-side BID
//  bresp_i              in   N_INIT_PORT*2           initiator-side BRESP
//  buser_i              in   N_INIT_PORT*AXI_USER_W  initiator-side BUSER
//  bvalid_i             in   N_INIT_PORT             initiator-side BVALID
//  bready_o             out  N_INIT_PORT             initiator-side BREADY
//  bid_o                out  AXI_ID_IN               target-side BID
//  bresp_o              out  2                       target-side BRESP
//  buser_o              out  AXI_USER_W              target-side BUSER
//  bvalid_o             out  1                       target-side BVALID
//  bready_i             in   1                       target-side BREADY
//  incr_req_i           in   1                       AW accepted by an initiator: count +1
//  full_counter_o       out  1                       counter == MAX_OUTSTANDING
//  outstanding_trans_o  out  1                       counter != 0
//  error_req_i          in   1                       DECERR response requested (W beats already drained)
//  error_id_i           in   AXI_ID_IN               ID for DECERR response
//  error_user_i         in   AXI_USER_W              USER for DECERR response
//  error_gnt_o          out  1                       one-cycle pulse: DECERR response accepted
// BEHAVIOUR
//  Reset: bvalid_o=0, bready_o=0, error_gnt_o=0; counter=0; rr pointer=0; bid_o/bresp_o/buser_o=0.
//  Reset mid-burst discards all state, including a held response and any pending error.
//  Arbiter: round-robin over bvalid_i, starting search at ptr. Only the granted port sees bready_o=1 (=bready_i).
//  Lock: while bvalid_o && !bready_i, the grant and output payload are held stable.
//  On handshake, ptr <= granted index + 1 (mod N_INIT_PORT).
//  bid_o = bid_i[g][AXI_ID_IN-1:0]; upper routing bits are dropped. bresp_o and buser_o pass through.
//  Counter: incr_req_i && !full -> +1; normal B handshake -> -1; both in one cycle -> unchanged.
//  incr_req_i while full is ignored and flagged by an assertion. Decrement at 0 is an assertion error; the counter holds.
//  Error path: error_req_i is served only when counter==0 and no initiator-side B is being presented.
//    Output is bresp_o=2'b11 (DECERR) with error_id_i and error_user_i. The counter is not touched.
//    error_gnt_o pulses on the accepting handshake; the requester drops error_req_i the next cycle.
//  Error has lower priority than normal responses; starvation is impossible because counter==0 implies no further normal B.
//  Latency without the macro: 0 cycles, combinational from bvalid_i to bvalid_o.
// CONFIGURATION
//  AXI_BRESP_REG_EN defined: one-entry output register. bvalid_o, bid_o, bresp_o and buser_o are registered (1-cycle latency).
//    Register loads when empty or draining in the same cycle (full throughput). bready_o = reg_empty || bready_i.
//    Counter decrement and error_gnt_o are taken at register load.
//  Not defined: purely combinational datapath; the counter decrements at the target-side handshake.
// STRUCTURE
//  axi_node_pkg: RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR constants; b_chan_t struct {id,resp,user}.
//  Sub-module axi_rr_arbiter (N requesters, lock input, one-hot grant + index out), reusable by the R collector.
//  Counter, error injection and optional register stay in this module.
// TESTING
//  Reset: after rst=1 for 2 cycles, bvalid_o=0, bready_o=0, full_counter_o=0, outstanding_trans_o=0.
//  RR fairness: bvalid_i=4'b1111 held, bready_i=1 -> grants 0,1,2,3,0 on consecutive cycles; bid_o = low 16 bits of each bid_i.
//  Backpressure: bvalid_i[2]=1, bready_i=0 for 5 cycles, then bvalid_i[1] rises -> port 2 is held stable and served first.
//  Counter: 8 incr_req_i pulses -> full_counter_o=1; 9th pulse ignored; incr and handshake in the same cycle -> count stays 8.
//  Error: 2 outstanding, error_req_i id=0x00A5 -> no grant until both B handshakes done; then bresp_o=2'b11, bid_o=0x00A5, error_gnt_o pulses once.
//  REG_EN build: back-to-back B responses with bready_i=1 -> 1 response/cycle at 1-cycle latency; mid-stream reset clears bvalid_o next cycle.

Source files
------------

// File: rtl/axi_node_pkg.sv
// Shared AXI node constants: response codes used by the B/R collectors.
package axi_node_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int B_ID_W_DEF   = 16;
  localparam int B_USER_W_DEF = 6;

  typedef struct packed {
    logic [B_ID_W_DEF-1:0]   id;
    logic [1:0]              resp;
    logic [B_USER_W_DEF-1:0] user;
  } b_chan_t;

endpackage

// File: rtl/axi_rr_arbiter.sv
// Round-robin arbiter with grant lock; one-hot grant plus index.
module axi_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          lock,
  input  logic          adv,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] hold_idx_q;
  logic          hold_q;

  // Descending scan so the lowest offset from ptr wins.
  always_comb begin
    idx   = ptr_q;
    valid = 1'b0;
    if (hold_q) begin
      idx   = hold_idx_q;
      valid = req[hold_idx_q];
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (req[(int'(ptr_q) + k) % N]) begin
          idx   = IW'((int'(ptr_q) + k) % N);
          valid = 1'b1;
        end
      end
    end
    gnt = '0;
    if (valid) gnt[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      hold_q     <= lock && valid;
      hold_idx_q <= idx;
      if (adv)
        ptr_q <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/axi_bresp_collector.sv
// B-channel collector: RR merge, ID strip, outstanding count, DECERR inject.
// Optional output register enabled by defining AXI_BRESP_REG_EN.
module axi_bresp_collector
  import axi_node_pkg::*;
#(
  parameter int N_INIT_PORT     = 4,
  parameter int N_TARG_PORT     = 8,
  parameter int AXI_ID_IN       = 16,
  parameter int AXI_ID_OUT      = AXI_ID_IN + $clog2(N_TARG_PORT),
  parameter int AXI_USER_W      = 6,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_INIT_PORT*AXI_ID_OUT-1:0] bid_i,
  input  logic [N_INIT_PORT*2-1:0]          bresp_i,
  input  logic [N_INIT_PORT*AXI_USER_W-1:0] buser_i,
  input  logic [N_INIT_PORT-1:0]            bvalid_i,
  output logic [N_INIT_PORT-1:0]            bready_o,
  output logic [AXI_ID_IN-1:0]              bid_o,
  output logic [1:0]                        bresp_o,
  output logic [AXI_USER_W-1:0]             buser_o,
  output logic                              bvalid_o,
  input  logic                              bready_i,
  input  logic                              incr_req_i,
  output logic                              full_counter_o,
  output logic                              outstanding_trans_o,
  input  logic                              error_req_i,
  input  logic [AXI_ID_IN-1:0]              error_id_i,
  input  logic [AXI_USER_W-1:0]             error_user_i,
  output logic                              error_gnt_o
);

  localparam int N     = N_INIT_PORT;
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int RW    = AXI_ID_OUT - AXI_ID_IN;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [AXI_ID_IN-1:0]  id;
    logic [1:0]            resp;
    logic [AXI_USER_W-1:0] user;
  } bc_t;

  bc_t           in_b [N];
  bc_t           sel_b;
  bc_t           err_b;
  bc_t           out_b;
  logic [RW-1:0] route [N];
  logic          unused_route;

  logic [N-1:0]  gnt;
  logic [IW-1:0] gidx;
  logic          gvalid;
  logic          lock;
  logic          take;
  logic          dec;
  logic          inc;
  logic          err_sel;
  logic [CNT_W-1:0] cnt_q;

  for (genvar p = 0; p < N; p++) begin : g_in
    assign in_b[p] = {bid_i[p*AXI_ID_OUT +: AXI_ID_IN],
                      bresp_i[p*2 +: 2],
                      buser_i[p*AXI_USER_W +: AXI_USER_W]};
    assign route[p] = bid_i[p*AXI_ID_OUT+AXI_ID_IN +: RW];
  end

  always_comb begin
    unused_route = 1'b0;
    for (int p = 0; p < N; p++) unused_route = unused_route ^ (^route[p]);
  end

  assign sel_b = in_b[gidx];
  assign err_b = {error_id_i, RESP_DECERR, error_user_i};

  assign full_counter_o      = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign outstanding_trans_o = (cnt_q != '0);
  assign err_sel = error_req_i && !outstanding_trans_o && !gvalid;

  axi_rr_arbiter #(.N(N)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (bvalid_i),
    .lock  (lock),
    .adv   (dec),
    .gnt   (gnt),
    .idx   (gidx),
    .valid (gvalid)
  );

`ifdef AXI_BRESP_REG_EN
  logic v_q;
  bc_t  out_q;

  // Register accepts a new beat when empty or draining this cycle.
  assign take = !v_q || bready_i;
  assign lock = gvalid && !take;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= 1'b0;
      out_q <= '0;
    end else if (gvalid && take) begin
      v_q   <= 1'b1;
      out_q <= sel_b;
    end else if (err_sel && take) begin
      v_q   <= 1'b1;
      out_q <= err_b;
    end else if (bready_i) begin
      v_q   <= 1'b0;
    end
  end

  assign bvalid_o = v_q;
  assign out_b    = out_q;
`else
  assign take = bready_i;
  assign lock = gvalid && !bready_i;

  always_comb begin
    out_b = '0;
    if (!rst) begin
      unique case (1'b1)
        gvalid:  out_b = sel_b;
        err_sel: out_b = err_b;
        default: out_b = '0;
      endcase
    end
  end

  assign bvalid_o = !rst && (gvalid || err_sel);
`endif

  assign bid_o   = out_b.id;
  assign bresp_o = out_b.resp;
  assign buser_o = out_b.user;

  assign bready_o    = rst ? '0 : (gnt & {N{take}});
  assign error_gnt_o = !rst && err_sel && take;

  assign dec = gvalid && take;
  // A freed slot lets a new AW in even when the counter sits at max.
  assign inc = incr_req_i && (!full_counter_o || dec);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc && !dec) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (dec && !inc && outstanding_trans_o) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

`ifndef SYNTHESIS
  a_incr_full: assert property (@(posedge clk) disable iff (rst)
    !(incr_req_i && full_counter_o && !dec));
  a_dec_zero: assert property (@(posedge clk) disable iff (rst)
    !(dec && !outstanding_trans_o && !incr_req_i));
`endif

endmodule
